// File: rtl/track_pkg.sv
// Shared types and widths for the centroid tracker box-size controller.
package track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_CLAMP,
        ST_UPDATE
    } state_t;

    localparam int CNT_W      = 20;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int RUN_W      = 4;
    localparam int DEF_HEIGHT = 150;
    localparam int DEF_WIDTH  = 150;

endpackage

// File: rtl/track_clamp.sv
// Centre +/- half-size with the low bound saturating at 0 and the high bound at MAX.
module track_clamp #(
    parameter int W   = 11,
    parameter int MAX = 524
) (
    input  logic [W-1:0] i_centre,
    input  logic [W-1:0] i_half,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam logic [W:0] L_MAX = (W+1)'(MAX);

    logic [W:0] w_sum;

    // One extra bit on the sum so a large centre plus half-size never wraps before the clamp.
    assign w_sum = {1'b0, i_centre} + {1'b0, i_half};
    assign o_lo  = (i_centre < i_half) ? '0 : (i_centre - i_half);
    assign o_hi  = (w_sum > L_MAX) ? L_MAX[W-1:0] : w_sum[W-1:0];

endmodule

// File: rtl/track_ctrl.sv
// Per-frame grow/shrink/hold controller for the tracking box, with lock and loss reporting.
module track_ctrl
    import track_pkg::*;
#(
    parameter int HEIGHT          = DEF_HEIGHT,
    parameter int WIDTH           = DEF_WIDTH,
    parameter int INCREMENT       = 10,
    parameter int TRACK_DIFF      = 10,
    parameter int TRACKBOUND_DIFF = 30,
    parameter int MAX_H           = 400,
    parameter int X_MAX           = 524,
    parameter int Y_MAX           = 524,
    parameter int LOCK_FRAMES     = 4,
    parameter int LOST_FRAMES     = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_stats_valid,
    output logic             o_stats_ready,
    input  logic [CNT_W-1:0] i_frame_count,
    input  logic [CNT_W-1:0] i_rect_count,
    input  logic [CNT_W-1:0] i_lrect_count,
    input  logic [X_W-1:0]   i_cx,
    input  logic [Y_W-1:0]   i_cy,
    output logic [Y_W-1:0]   o_height,
    output logic [X_W-1:0]   o_width,
    output logic [Y_W-1:0]   o_last_height,
    output logic [X_W-1:0]   o_last_width,
    output logic [X_W-1:0]   o_x_lo,
    output logic [X_W-1:0]   o_x_hi,
    output logic [Y_W-1:0]   o_y_lo,
    output logic [Y_W-1:0]   o_y_hi,
    output logic             o_upd_valid,
    output logic             o_locked,
    output logic             o_lost
);

    localparam logic [Y_W-1:0]   L_HEIGHT     = Y_W'(HEIGHT);
    localparam logic [X_W-1:0]   L_WIDTH      = X_W'(WIDTH);
    localparam logic [Y_W:0]     L_INC        = (Y_W+1)'(INCREMENT);
    localparam logic [Y_W:0]     L_MAX_H      = (Y_W+1)'(MAX_H);
    localparam logic [CNT_W-1:0] L_TRACK_DIFF = CNT_W'(TRACK_DIFF);
    localparam logic [CNT_W-1:0] L_BOUND_DIFF = CNT_W'(TRACKBOUND_DIFF);
    localparam logic [RUN_W-1:0] L_LOCK       = RUN_W'(LOCK_FRAMES);
    localparam logic [RUN_W-1:0] L_LOST       = RUN_W'(LOST_FRAMES);

    state_t           r_state;
    logic [CNT_W-1:0] r_frame, r_rect, r_lrect;
    logic [X_W-1:0]   r_cx;
    logic [Y_W-1:0]   r_cy;
    logic [Y_W-1:0]   r_newHeight, r_newLastHeight;
    logic [X_W-1:0]   r_newWidth, r_newLastWidth;
    logic [X_W-1:0]   r_xLo, r_xHi;
    logic [Y_W-1:0]   r_yLo, r_yHi;
    logic [RUN_W-1:0] r_growRun, r_stableRun;
    logic             r_lostPend;

    logic [CNT_W-1:0] w_outDiff, w_inDiff;
    logic [Y_W:0]     w_hSum, w_lhSum;
    logic [Y_W-1:0]   w_hGrow, w_lhGrow;
    logic [RUN_W-1:0] w_growInc, w_stableInc;
    logic             w_grow, w_shrink;
    logic [Y_W-1:0]   w_nextH, w_nextLh;
    logic [RUN_W-1:0] w_nextGrowRun, w_nextStableRun;
    logic             w_nextLost;
    logic [X_W-1:0]   w_xLo, w_xHi;
    logic [Y_W-1:0]   w_yLo, w_yHi;

    assign w_outDiff   = (r_frame > r_rect) ? (r_frame - r_rect) : '0;
    assign w_inDiff    = (r_lrect > r_rect) ? (r_lrect - r_rect) : '0;
    assign w_hSum      = {1'b0, o_height} + L_INC;
    assign w_lhSum     = {1'b0, o_last_height} + L_INC;
    assign w_hGrow     = (w_hSum > L_MAX_H) ? L_MAX_H[Y_W-1:0] : w_hSum[Y_W-1:0];
    assign w_lhGrow    = (w_lhSum > L_MAX_H) ? L_MAX_H[Y_W-1:0] : w_lhSum[Y_W-1:0];
    assign w_growInc   = (r_growRun == '1) ? r_growRun : (r_growRun + RUN_W'(1));
    assign w_stableInc = (r_stableRun == '1) ? r_stableRun : (r_stableRun + RUN_W'(1));
    assign w_grow      = (w_outDiff >= L_BOUND_DIFF);
    assign w_shrink    = ({1'b0, o_height} > L_INC) && (w_inDiff < L_TRACK_DIFF);

    // A grow frame that completes a full run of growth means the target is gone.
    always_comb begin
        w_nextH         = o_height;
        w_nextLh        = o_last_height;
        w_nextGrowRun   = '0;
        w_nextStableRun = w_stableInc;
        w_nextLost      = 1'b0;
        if (w_grow) begin
            w_nextH         = w_hGrow;
            w_nextLh        = w_lhGrow;
            w_nextGrowRun   = w_growInc;
            w_nextStableRun = '0;
            if (w_growInc >= L_LOST) begin
                w_nextH       = L_HEIGHT;
                w_nextLh      = L_HEIGHT;
                w_nextGrowRun = '0;
                w_nextLost    = 1'b1;
            end
        end else if (w_shrink) begin
            w_nextLh = o_height;
            w_nextH  = o_height - L_INC[Y_W-1:0];
        end
    end

    track_clamp #(.W(X_W), .MAX(X_MAX)) u_clampX (
        .i_centre (r_cx),
        .i_half   (r_newWidth),
        .o_lo     (w_xLo),
        .o_hi     (w_xHi)
    );

    track_clamp #(.W(Y_W), .MAX(Y_MAX)) u_clampY (
        .i_centre (r_cy),
        .i_half   (r_newHeight),
        .o_lo     (w_yLo),
        .o_hi     (w_yHi)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ST_IDLE;
            r_frame         <= '0;
            r_rect          <= '0;
            r_lrect         <= '0;
            r_cx            <= '0;
            r_cy            <= '0;
            r_newHeight     <= L_HEIGHT;
            r_newLastHeight <= L_HEIGHT;
            r_newWidth      <= L_WIDTH;
            r_newLastWidth  <= L_WIDTH;
            r_xLo           <= '0;
            r_xHi           <= '0;
            r_yLo           <= '0;
            r_yHi           <= '0;
            r_growRun       <= '0;
            r_stableRun     <= '0;
            r_lostPend      <= 1'b0;
            o_stats_ready   <= 1'b1;
            o_height        <= L_HEIGHT;
            o_width         <= L_WIDTH;
            o_last_height   <= L_HEIGHT;
            o_last_width    <= L_WIDTH;
            o_x_lo          <= '0;
            o_x_hi          <= '0;
            o_y_lo          <= '0;
            o_y_hi          <= '0;
            o_upd_valid     <= 1'b0;
            o_locked        <= 1'b0;
            o_lost          <= 1'b0;
        end else begin
            o_upd_valid <= 1'b0;
            o_lost      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // With enable low the handshake still completes so the producer never stalls.
                    if (i_stats_valid && o_stats_ready && i_enable) begin
                        r_frame       <= i_frame_count;
                        r_rect        <= i_rect_count;
                        r_lrect       <= i_lrect_count;
                        r_cx          <= i_cx;
                        r_cy          <= i_cy;
                        o_stats_ready <= 1'b0;
                        r_state       <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    r_newHeight     <= w_nextH;
                    r_newLastHeight <= w_nextLh;
                    r_newWidth      <= w_nextLost ? L_WIDTH : {1'b0, w_nextH};
                    r_newLastWidth  <= w_nextLost ? L_WIDTH : {1'b0, w_nextLh};
                    r_growRun       <= w_nextGrowRun;
                    r_stableRun     <= w_nextStableRun;
                    r_lostPend      <= w_nextLost;
                    r_state         <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    r_xLo   <= w_xLo;
                    r_xHi   <= w_xHi;
                    r_yLo   <= w_yLo;
                    r_yHi   <= w_yHi;
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    o_height      <= r_newHeight;
                    o_width       <= r_newWidth;
                    o_last_height <= r_newLastHeight;
                    o_last_width  <= r_newLastWidth;
                    o_x_lo        <= r_xLo;
                    o_x_hi        <= r_xHi;
                    o_y_lo        <= r_yLo;
                    o_y_hi        <= r_yHi;
                    o_locked      <= (r_stableRun >= L_LOCK);
                    o_lost        <= r_lostPend;
                    o_upd_valid   <= 1'b1;
                    o_stats_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_track_ctrl.sv
// Self-checking bench for track_ctrl: table-driven frames, a scoreboard queue, and hand-written
// sequences for disable, backpressure, reset mid-operation, loss and the growth ceiling.
module tb_track_ctrl;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  lh;
        logic [10:0] w;
        logic [10:0] lw;
        logic [10:0] xlo;
        logic [10:0] xhi;
        logic [9:0]  ylo;
        logic [9:0]  yhi;
        logic        locked;
        logic        lost;
    } exp_t;

    typedef struct {
        logic [19:0] frame;
        logic [19:0] rect;
        logic [19:0] lrect;
        logic [10:0] cx;
        logic [9:0]  cy;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic        statsValid;
    logic        statsReady;
    logic [19:0] frameCount, rectCount, lrectCount;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [9:0]  height, lastHeight, yLo, yHi;
    logic [10:0] width, lastWidth, xLo, xHi;
    logic        updValid, locked, lost;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];
    vec_t table_v[9];

    always #5 clk = ~clk;

    track_ctrl dut (
        .i_clk         (clk),
        .i_reset_n     (resetN),
        .i_enable      (enable),
        .i_stats_valid (statsValid),
        .o_stats_ready (statsReady),
        .i_frame_count (frameCount),
        .i_rect_count  (rectCount),
        .i_lrect_count (lrectCount),
        .i_cx          (cx),
        .i_cy          (cy),
        .o_height      (height),
        .o_width       (width),
        .o_last_height (lastHeight),
        .o_last_width  (lastWidth),
        .o_x_lo        (xLo),
        .o_x_hi        (xHi),
        .o_y_lo        (yLo),
        .o_y_hi        (yHi),
        .o_upd_valid   (updValid),
        .o_locked      (locked),
        .o_lost        (lost)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampLo(input int c, input int h);
        return (c < h) ? 0 : c - h;
    endfunction

    function automatic int clampHi(input int c, input int h, input int mx);
        return (c + h > mx) ? mx : c + h;
    endfunction

    function automatic vec_t mkVec(input int f, input int r, input int l, input int x, input int y,
                                   input int h, input int lh, input int xl, input int xh,
                                   input int yl, input int yh, input int lk, input int ls);
        vec_t v;
        v.frame      = 20'(f);
        v.rect       = 20'(r);
        v.lrect      = 20'(l);
        v.cx         = 11'(x);
        v.cy         = 10'(y);
        v.exp.h      = 10'(h);
        v.exp.lh     = 10'(lh);
        v.exp.w      = 11'(h);
        v.exp.lw     = 11'(lh);
        v.exp.xlo    = 11'(xl);
        v.exp.xhi    = 11'(xh);
        v.exp.ylo    = 10'(yl);
        v.exp.yhi    = 10'(yh);
        v.exp.locked = lk[0];
        v.exp.lost   = ls[0];
        return v;
    endfunction

    // Expected frame model: builds a vector from the bench's own height/lock/loss bookkeeping.
    function automatic vec_t modelVec(input int f, input int r, input int l, input int h,
                                      input int lh, input int lk, input int ls);
        return mkVec(f, r, l, 300, 200, h, lh, clampLo(300, h), clampHi(300, h, 524),
                     clampLo(200, h), clampHi(200, h, 524), lk, ls);
    endfunction

    task automatic applyStimulus(input logic en, input vec_t v, input bit expectUpd);
        int waitCycles;
        int lat;
        @(negedge clk);
        enable     = en;
        frameCount = v.frame;
        rectCount  = v.rect;
        lrectCount = v.lrect;
        cx         = v.cx;
        cy         = v.cy;
        statsValid = 1'b1;
        waitCycles = 0;
        while (!statsReady && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("acceptReady", int'(statsReady), 1);
        if (expectUpd) expQ.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        statsValid = 1'b0;
        if (expectUpd) begin
            checkOutput("busyReady", int'(statsReady), 0);
            lat = 1;
            while (!updValid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("updLatency", lat, 4);
        end
    endtask

    // Scoreboard: every update pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetN) begin
            if (lost) checkOutput("lostWithUpd", int'(updValid), 1);
            if (updValid) begin
                checkOutput("scoreboardNonEmpty", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    automatic exp_t e = expQ.pop_front();
                    checkOutput("height", int'(height), int'(e.h));
                    checkOutput("width", int'(width), int'(e.w));
                    checkOutput("lastHeight", int'(lastHeight), int'(e.lh));
                    checkOutput("lastWidth", int'(lastWidth), int'(e.lw));
                    checkOutput("xLo", int'(xLo), int'(e.xlo));
                    checkOutput("xHi", int'(xHi), int'(e.xhi));
                    checkOutput("yLo", int'(yLo), int'(e.ylo));
                    checkOutput("yHi", int'(yHi), int'(e.yhi));
                    checkOutput("locked", int'(locked), int'(e.locked));
                    checkOutput("lost", int'(lost), int'(e.lost));
                    checkOutput("readyWithUpd", int'(statsReady), 1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;
        int mh;
        vec_t v;

        // Hand-computed frame sequence starting from reset defaults (h=lh=150).
        table_v[0] = mkVec(100, 50,  60, 300, 200, 160, 160, 140, 460,  40, 360, 0, 0);
        table_v[1] = mkVec( 55, 50,  52, 500,  20, 150, 160, 350, 524,   0, 170, 0, 0);
        table_v[2] = mkVec( 55, 50,  52, 300, 200, 140, 150, 160, 440,  60, 340, 0, 0);
        table_v[3] = mkVec( 55, 50,  52, 100, 100, 130, 140,   0, 230,   0, 230, 0, 0);
        table_v[4] = mkVec( 55, 50,  52, 524, 523, 120, 130, 404, 524, 403, 524, 1, 0);
        table_v[5] = mkVec( 50, 50,  70,   0,   0, 120, 130,   0, 120,   0, 120, 1, 0);
        table_v[6] = mkVec( 10, 50,  20, 110, 110, 110, 120,   0, 220,   0, 220, 1, 0);
        table_v[7] = mkVec( 80, 50, 100, 200, 150, 120, 130,  80, 320,  30, 270, 0, 0);
        table_v[8] = mkVec( 79, 50,  60, 200, 150, 120, 130,  80, 320,  30, 270, 0, 0);

        resetN     = 1'b0;
        enable     = 1'b1;
        statsValid = 1'b0;
        frameCount = '0;
        rectCount  = '0;
        lrectCount = '0;
        cx         = '0;
        cy         = '0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        checkOutput("resetHeight", int'(height), 150);
        checkOutput("resetWidth", int'(width), 150);
        checkOutput("resetReady", int'(statsReady), 1);
        checkOutput("resetUpd", int'(updValid), 0);
        checkOutput("resetLocked", int'(locked), 0);
        checkOutput("resetXHi", int'(xHi), 0);

        foreach (table_v[i]) applyStimulus(1'b1, table_v[i], 1'b1);

        // Disabled: summary accepted and discarded with no visible change.
        v = modelVec(100, 50, 60, 0, 0, 0, 0);
        applyStimulus(1'b0, v, 1'b0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(updValid);
            checkOutput("disabledReady", int'(statsReady), 1);
        end
        checkOutput("disabledNoUpd", pulses, 0);
        checkOutput("disabledHeight", int'(height), 120);
        enable = 1'b1;

        // Backpressure: valid held through the busy window is accepted exactly once.
        v = modelVec(50, 50, 70, 120, 130, 0, 0);
        @(negedge clk);
        frameCount = v.frame;
        rectCount  = v.rect;
        lrectCount = v.lrect;
        cx         = v.cx;
        cy         = v.cy;
        statsValid = 1'b1;
        checkOutput("bpAcceptReady", int'(statsReady), 1);
        expQ.push_back(v.exp);
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("bpBusyReady", int'(statsReady), 0);
        end
        @(negedge clk);
        statsValid = 1'b0;
        pulses = int'(updValid);
        repeat (8) begin
            @(negedge clk);
            pulses += int'(updValid);
        end
        checkOutput("bpAcceptedOnce", pulses, 1);

        // Reset while in CLAMP: work discarded, outputs snap to defaults.
        @(negedge clk);
        frameCount = 20'd100;
        rectCount  = 20'd50;
        lrectCount = 20'd60;
        cx         = 11'd300;
        cy         = 10'd200;
        statsValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        statsValid = 1'b0;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("midResetHeight", int'(height), 150);
        checkOutput("midResetLastHeight", int'(lastHeight), 150);
        checkOutput("midResetWidth", int'(width), 150);
        checkOutput("midResetXLo", int'(xLo), 0);
        checkOutput("midResetLocked", int'(locked), 0);
        checkOutput("midResetReady", int'(statsReady), 1);
        @(negedge clk);
        resetN = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(updValid);
        end
        checkOutput("midResetNoUpd", pulses, 0);

        // Loss: eight consecutive grow frames, the eighth reverts to defaults with lost.
        for (int k = 1; k <= 8; k++) begin
            mh = (k == 8) ? 150 : 150 + 10 * k;
            applyStimulus(1'b1, modelVec(100, 50, 60, mh, mh, 0, (k == 8) ? 1 : 0), 1'b1);
        end
        @(negedge clk);
        checkOutput("lostOneCycle", int'(lost), 0);
        checkOutput("updOneCycle", int'(updValid), 0);

        // Growth ceiling: grow runs broken by a hold every seventh frame so loss never fires.
        mh = 150;
        for (int i = 0; i < 30; i++) begin
            if ((i % 7) != 6) begin
                mh = (mh + 10 > 400) ? 400 : mh + 10;
                applyStimulus(1'b1, modelVec(100, 50, 60, mh, mh, 0, 0), 1'b1);
            end else begin
                applyStimulus(1'b1, modelVec(50, 50, 70, mh, mh, 0, 0), 1'b1);
            end
        end
        checkOutput("ceilingHeight", int'(height), 400);

        repeat (4) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
